// File: rtl/pll_lock_sequencer.sv
// ECP5 EHXPLLL lock sequencer: PLL reset pulsing, lock timeout/retry, fabric reset
// qualification and (when PLLSEQ_PHASE_STEP_EN is defined) dynamic phase stepping.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int STEP_PULSE    = 4,
    parameter int STEP_SETTLE   = 16
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       rst_out,
    output logic       lock_ok,
    output logic [7:0] retries,
    input  logic       step_valid,
    output logic       step_ready,
    input  logic [1:0] step_sel,
    input  logic       step_dir,
    input  logic [3:0] step_count,
    output logic [1:0] pll_phasesel,
    output logic       pll_phasedir,
    output logic       pll_phasestep,
    output logic       pll_phaseloadreg
);

    localparam int RST_W = (RST_CYCLES    > 1) ? $clog2(RST_CYCLES)    : 1;
    localparam int TO_W  = (LOCK_TIMEOUT  > 1) ? $clog2(LOCK_TIMEOUT)  : 1;
    localparam int STB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
    localparam logic [RST_W-1:0] RST_ONE  = RST_W'(1);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
    localparam logic [STB_W-1:0] STB_ONE  = STB_W'(1);

    typedef enum logic [2:0] {
        ST_RESET_PLL   = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_STABLE      = 3'd2,
        ST_RUN         = 3'd3,
        ST_STEP_SETUP  = 3'd4,
        ST_STEP_PULSE  = 3'd5,
        ST_STEP_SETTLE = 3'd6
    } state_t;

    state_t           state_r, state_s;
    logic             lk_meta_r, lk_r;
    logic [RST_W-1:0] rst_cnt_r, rst_cnt_s;
    logic [TO_W-1:0]  to_cnt_r, to_cnt_s;
    logic [STB_W-1:0] stb_cnt_r, stb_cnt_s;
    logic [7:0]       retries_r, retries_s;
    logic             run_like_s;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            sat_inc8 = value;
        end else begin
            sat_inc8 = value + 8'd1;
        end
    endfunction

`ifdef PLLSEQ_PHASE_STEP_EN
    localparam int SP_W = (STEP_PULSE  > 1) ? $clog2(STEP_PULSE)  : 1;
    localparam int SS_W = (STEP_SETTLE > 1) ? $clog2(STEP_SETTLE) : 1;
    localparam logic [SP_W-1:0] SP_LAST = SP_W'(STEP_PULSE - 1);
    localparam logic [SS_W-1:0] SS_LAST = SS_W'(STEP_SETTLE - 1);
    localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
    localparam logic [SS_W-1:0] SS_ONE  = SS_W'(1);

    logic [SP_W-1:0] pulse_cnt_r, pulse_cnt_s;
    logic [SS_W-1:0] settle_cnt_r, settle_cnt_s;
    logic [4:0]      rem_r, rem_s;
    logic [1:0]      sel_r, sel_s;
    logic            dir_r, dir_s;
`else
    logic unused_step_s;
    assign unused_step_s = ^{step_valid, step_sel, step_dir, step_count,
                             32'(STEP_PULSE), 32'(STEP_SETTLE)};
`endif

    // Two-flop synchronizer bringing the asynchronous PLL lock into the clock domain.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lk_meta_r <= 1'b0;
            lk_r      <= 1'b0;
        end else begin
            lk_meta_r <= pll_locked;
            lk_r      <= lk_meta_r;
        end
    end

    // Sequencer state, per-state counters and retry count.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_RESET_PLL;
            rst_cnt_r <= {RST_W{1'b0}};
            to_cnt_r  <= {TO_W{1'b0}};
            stb_cnt_r <= {STB_W{1'b0}};
            retries_r <= 8'd0;
        end else begin
            state_r   <= state_s;
            rst_cnt_r <= rst_cnt_s;
            to_cnt_r  <= to_cnt_s;
            stb_cnt_r <= stb_cnt_s;
            retries_r <= retries_s;
        end
    end

`ifdef PLLSEQ_PHASE_STEP_EN
    // Phase-step request latch and step timing counters.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pulse_cnt_r  <= {SP_W{1'b0}};
            settle_cnt_r <= {SS_W{1'b0}};
            rem_r        <= 5'd0;
            sel_r        <= 2'd0;
            dir_r        <= 1'b1;
        end else begin
            pulse_cnt_r  <= pulse_cnt_s;
            settle_cnt_r <= settle_cnt_s;
            rem_r        <= rem_s;
            sel_r        <= sel_s;
            dir_r        <= dir_s;
        end
    end
`endif

    // Next-state logic; counters default to zero so each one starts clean on state entry.
    always_comb begin
        state_s   = state_r;
        rst_cnt_s = {RST_W{1'b0}};
        to_cnt_s  = {TO_W{1'b0}};
        stb_cnt_s = {STB_W{1'b0}};
        retries_s = retries_r;
`ifdef PLLSEQ_PHASE_STEP_EN
        pulse_cnt_s  = {SP_W{1'b0}};
        settle_cnt_s = {SS_W{1'b0}};
        rem_s        = rem_r;
        sel_s        = sel_r;
        dir_s        = dir_r;
`endif
        case (state_r)
            ST_RESET_PLL: begin
                if (rst_cnt_r == RST_LAST) begin
                    state_s = ST_WAIT_LOCK;
                end else begin
                    rst_cnt_s = rst_cnt_r + RST_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (lk_r) begin
                    state_s = ST_STABLE;
                end else if (to_cnt_r == TO_LAST) begin
                    state_s   = ST_RESET_PLL;
                    retries_s = sat_inc8(retries_r);
                end else begin
                    to_cnt_s = to_cnt_r + TO_ONE;
                end
            end
            ST_STABLE: begin
                if (!lk_r) begin
                    state_s = ST_WAIT_LOCK;
                end else if (stb_cnt_r == STB_LAST) begin
                    state_s = ST_RUN;
                end else begin
                    stb_cnt_s = stb_cnt_r + STB_ONE;
                end
            end
            ST_RUN: begin
                // Loss of lock outranks a simultaneous step request.
                if (!lk_r) begin
                    state_s = ST_WAIT_LOCK;
`ifdef PLLSEQ_PHASE_STEP_EN
                    rem_s   = 5'd0;
                end else if (step_valid) begin
                    state_s = ST_STEP_SETUP;
                    sel_s   = step_sel;
                    dir_s   = step_dir;
                    rem_s   = (step_count == 4'd0) ? 5'd16 : {1'b0, step_count};
`endif
                end else begin
                    state_s = ST_RUN;
                end
            end
`ifdef PLLSEQ_PHASE_STEP_EN
            ST_STEP_SETUP: begin
                if (!lk_r) begin
                    state_s = ST_WAIT_LOCK;
                    rem_s   = 5'd0;
                end else begin
                    state_s = ST_STEP_PULSE;
                end
            end
            ST_STEP_PULSE: begin
                if (!lk_r) begin
                    state_s = ST_WAIT_LOCK;
                    rem_s   = 5'd0;
                end else if (pulse_cnt_r == SP_LAST) begin
                    state_s = ST_STEP_SETTLE;
                end else begin
                    pulse_cnt_s = pulse_cnt_r + SP_ONE;
                end
            end
            ST_STEP_SETTLE: begin
                if (!lk_r) begin
                    state_s = ST_WAIT_LOCK;
                    rem_s   = 5'd0;
                end else if (settle_cnt_r == SS_LAST) begin
                    rem_s   = rem_r - 5'd1;
                    state_s = (rem_r == 5'd1) ? ST_RUN : ST_STEP_PULSE;
                end else begin
                    settle_cnt_s = settle_cnt_r + SS_ONE;
                end
            end
`endif
            default: begin
                state_s = ST_RESET_PLL;
            end
        endcase
    end

    // Output decode; lock-dependent outputs react in the same cycle lk drops.
    always_comb begin
        run_like_s = (state_r == ST_RUN)        || (state_r == ST_STEP_SETUP) ||
                     (state_r == ST_STEP_PULSE) || (state_r == ST_STEP_SETTLE);
        pll_rst          = (state_r == ST_RESET_PLL);
        rst_out          = !(run_like_s && lk_r);
        lock_ok          = run_like_s && lk_r;
        retries          = retries_r;
        pll_phaseloadreg = 1'b1;
`ifdef PLLSEQ_PHASE_STEP_EN
        step_ready       = (state_r == ST_RUN) && lk_r;
        pll_phasestep    = !((state_r == ST_STEP_PULSE) && lk_r);
        pll_phasesel     = sel_r;
        pll_phasedir     = dir_r;
`else
        step_ready       = 1'b0;
        pll_phasestep    = 1'b1;
        pll_phasesel     = 2'd0;
        pll_phasedir     = 1'b1;
`endif
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomized self-checking bench for pll_lock_sequencer; expected timing is derived
// from lock-arrival arithmetic rather than a cycle-by-cycle state machine.
module tb_pll_lock_sequencer;

    localparam int RST_C    = 4;
    localparam int TO_C     = 100;
    localparam int STB_C    = 8;
    localparam int SP_C     = 2;
    localparam int SS_C     = 3;
    localparam int PERIOD_C = RST_C + TO_C;
    localparam int STEP_C   = SP_C + SS_C;

    logic       clock      = 1'b0;
    logic       resetn     = 1'b0;
    logic       pll_locked = 1'b0;
    logic       step_valid = 1'b0;
    logic [1:0] step_sel   = 2'd0;
    logic       step_dir   = 1'b0;
    logic [3:0] step_count = 4'd0;
    logic       pll_rst, rst_out, lock_ok, step_ready;
    logic [7:0] retries;
    logic [1:0] pll_phasesel;
    logic       pll_phasedir, pll_phasestep, pll_phaseloadreg;

    pll_lock_sequencer #(
        .RST_CYCLES(RST_C), .LOCK_TIMEOUT(TO_C), .STABLE_CYCLES(STB_C),
        .STEP_PULSE(SP_C), .STEP_SETTLE(SS_C)
    ) dut (
        .clock(clock), .resetn(resetn), .pll_locked(pll_locked),
        .pll_rst(pll_rst), .rst_out(rst_out), .lock_ok(lock_ok), .retries(retries),
        .step_valid(step_valid), .step_ready(step_ready), .step_sel(step_sel),
        .step_dir(step_dir), .step_count(step_count), .pll_phasesel(pll_phasesel),
        .pll_phasedir(pll_phasedir), .pll_phasestep(pll_phasestep),
        .pll_phaseloadreg(pll_phaseloadreg)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: observed %0d, expected %0d", tag, cyc, obs, exp);
    endtask

    // Cycle n is the interval after the n-th rising edge following reset release.
    task automatic go(input int c);
        while (cyc < c) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    // Lock driven in cycle L is seen two cycles later; the sequencer needs one cycle to
    // notice it in WAIT_LOCK (which starts RST_C cycles into an attempt), then STB_C
    // qualified cycles before the fabric reset is released.
    function automatic int run_cycle(input int lock_drive, input int attempt_start);
        int seen       = lock_drive + 2;
        int wait_start = attempt_start + RST_C;
        return ((seen > wait_start) ? seen : wait_start) + 1 + STB_C;
    endfunction

    task automatic check_reset_values(input string tag);
        check_eq({tag, ".pll_rst"},    32'(pll_rst),          32'd1);
        check_eq({tag, ".rst_out"},    32'(rst_out),          32'd1);
        check_eq({tag, ".lock_ok"},    32'(lock_ok),          32'd0);
        check_eq({tag, ".retries"},    32'(retries),          32'd0);
        check_eq({tag, ".step_ready"}, 32'(step_ready),       32'd0);
        check_eq({tag, ".phasesel"},   32'(pll_phasesel),     32'd0);
        check_eq({tag, ".phasedir"},   32'(pll_phasedir),     32'd1);
        check_eq({tag, ".phasestep"},  32'(pll_phasestep),    32'd1);
        check_eq({tag, ".loadreg"},    32'(pll_phaseloadreg), 32'd1);
    endtask

    task automatic release_reset();
        resetn     = 1'b0;
        pll_locked = 1'b0;
        step_valid = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_values("in_reset");
        resetn = 1'b1;
        cyc    = 0;
    endtask

    task automatic bring_up(input int lock_at, output int run_at);
        release_reset();
        run_at = run_cycle(lock_at, 0);
        for (int c = 0; c <= run_at; c++) begin
            go(c);
            if (c <= RST_C) check_eq("bringup.pll_rst", 32'(pll_rst), 32'(c < RST_C));
            if (c == run_at - 1) begin
                check_eq("bringup.rst_out_held", 32'(rst_out), 32'd1);
                check_eq("bringup.lock_ok_low",  32'(lock_ok), 32'd0);
            end
            if (c == run_at) begin
                check_eq("bringup.rst_out_rel", 32'(rst_out), 32'd0);
                check_eq("bringup.lock_ok",     32'(lock_ok), 32'd1);
                check_eq("bringup.retries",     32'(retries), 32'd0);
`ifdef PLLSEQ_PHASE_STEP_EN
                check_eq("bringup.step_ready",  32'(step_ready), 32'd1);
`else
                check_eq("bringup.step_ready",  32'(step_ready), 32'd0);
`endif
            end
            if (c == lock_at) pll_locked = 1'b1;
        end
    endtask

`ifdef PLLSEQ_PHASE_STEP_EN
    // Issues one request from RUN; drop_at < 0 means lock stays up throughout.
    task automatic do_step(input logic [1:0] sel, input logic dir, input logic [3:0] count,
                           input int drop_at);
        int   a      = cyc;
        int   n      = (count == 4'd0) ? 16 : int'(count);
        int   e      = a + 2 + STEP_C * n;
        int   relock = (drop_at >= 0) ? run_cycle(drop_at + 3, 0) : -1;
        int   last   = (drop_at >= 0) ? relock + 3 : e + 2;
        logic lost, in_pulse;
        check_eq("step.ready_before", 32'(step_ready), 32'd1);
        step_valid = 1'b1;
        step_sel   = sel;
        step_dir   = dir;
        step_count = count;
        for (int c = a + 1; c <= last; c++) begin
            go(c);
            lost = (drop_at >= 0) && (c >= drop_at + 2);
            check_eq("step.loadreg", 32'(pll_phaseloadreg), 32'd1);
            if (lost) begin
                check_eq("loss.phasestep", 32'(pll_phasestep), 32'd1);
                check_eq("loss.rst_out",   32'(rst_out),       32'(c < relock));
                check_eq("loss.lock_ok",   32'(lock_ok),       32'(c >= relock));
                check_eq("loss.ready",     32'(step_ready),    32'(c >= relock));
            end else begin
                in_pulse = (c >= a + 2) && (c < e) && (((c - a - 2) % STEP_C) < SP_C);
                check_eq("step.phasestep", 32'(pll_phasestep), 32'(!in_pulse));
                check_eq("step.ready",     32'(step_ready),    32'(c >= e));
                check_eq("step.rst_out",   32'(rst_out),       32'd0);
                if (c < e) begin
                    check_eq("step.phasesel", 32'(pll_phasesel), 32'(sel));
                    check_eq("step.phasedir", 32'(pll_phasedir), 32'(dir));
                end
            end
            if (c == a + 1) step_valid = 1'b0;
            if (c == drop_at) pll_locked = 1'b0;
            if (c == drop_at + 3) pll_locked = 1'b1;
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, lk_at, glen, l2, cnt;

        // Normal bring-up: fixed lock at cycle 20, then random lock times.
        for (int t = 0; t < 3; t++) begin
            lk_at = (t == 0) ? 20 : int'($urandom_range(0, 90));
            bring_up(lk_at, r);
        end

        // Timeout retry: three timeouts, then lock during the fourth attempt.
        release_reset();
        for (int k = 0; k < 3; k++) begin
            go(k * PERIOD_C + 1);
            check_eq("retry.count",     32'(retries), 32'(k));
            check_eq("retry.rst_start", 32'(pll_rst), 32'd1);
            go(k * PERIOD_C + RST_C - 1);
            check_eq("retry.rst_end",   32'(pll_rst), 32'd1);
            go(k * PERIOD_C + RST_C);
            check_eq("retry.rst_off",   32'(pll_rst), 32'd0);
            go(k * PERIOD_C + PERIOD_C - 1);
            check_eq("retry.wait_last", 32'(pll_rst), 32'd0);
            check_eq("retry.rst_out",   32'(rst_out), 32'd1);
        end
        go(3 * PERIOD_C + 1);
        check_eq("retry.count3", 32'(retries), 32'd3);
        check_eq("retry.pulse4", 32'(pll_rst), 32'd1);
        lk_at = 3 * PERIOD_C + 1 + int'($urandom_range(0, 60));
        go(lk_at);
        pll_locked = 1'b1;
        r = run_cycle(lk_at, 3 * PERIOD_C);
        go(r - 1);
        check_eq("retry.rst_out_held", 32'(rst_out), 32'd1);
        go(r);
        check_eq("retry.run_rst_out", 32'(rst_out), 32'd0);
        check_eq("retry.run_lock_ok", 32'(lock_ok), 32'd1);
        check_eq("retry.run_retries", 32'(retries), 32'd3);

        // Retry counter saturation at 255.
        release_reset();
        go(255 * PERIOD_C + 1);
        check_eq("sat.255", 32'(retries), 32'd255);
        go(256 * PERIOD_C + 1);
        check_eq("sat.hold", 32'(retries), 32'd255);
        lk_at = 256 * PERIOD_C + 1 + int'($urandom_range(0, 40));
        go(lk_at);
        pll_locked = 1'b1;
        r = run_cycle(lk_at, 256 * PERIOD_C);
        go(r);
        check_eq("sat.run_rst_out", 32'(rst_out), 32'd0);
        check_eq("sat.run_retries", 32'(retries), 32'd255);

        // Glitchy lock: a short pulse never releases reset; a later steady lock does.
        for (int t = 0; t < 2; t++) begin
            release_reset();
            lk_at = int'($urandom_range(4, 30));
            glen  = (t == 0) ? 5 : int'($urandom_range(1, STB_C));
            l2    = lk_at + glen + int'($urandom_range(8, 20));
            r     = run_cycle(l2, 0);
            for (int c = 0; c <= r; c++) begin
                go(c);
                if (c >= lk_at) check_eq("glitch.rst_out", 32'(rst_out), 32'(c < r));
                if (c == lk_at) pll_locked = 1'b1;
                if (c == lk_at + glen) pll_locked = 1'b0;
                if (c == l2) pll_locked = 1'b1;
            end
        end

`ifdef PLLSEQ_PHASE_STEP_EN
        bring_up(20, r);
        do_step(2'd2, 1'b0, 4'd3, -1);
        go(cyc + int'($urandom_range(0, 3)));
        do_step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                4'($urandom_range(1, 15)), -1);
        go(cyc + 1);
        do_step(2'd1, 1'b1, 4'd0, -1);
        go(cyc + 2);
        do_step(2'd2, 1'b0, 4'd3, cyc + 7);
        go(cyc + 1);
        cnt = int'($urandom_range(1, 15));
        do_step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'(cnt),
                cyc + 1 + int'($urandom_range(0, STEP_C * cnt - 2)));
`else
        bring_up(20, r);
        step_valid = 1'b1;
        step_sel   = 2'($urandom_range(0, 3));
        step_dir   = 1'b0;
        step_count = 4'd3;
        for (int c = r + 1; c <= r + 6; c++) begin
            go(c);
            check_eq("nostep.ready",     32'(step_ready),    32'd0);
            check_eq("nostep.phasestep", 32'(pll_phasestep), 32'd1);
            check_eq("nostep.phasesel",  32'(pll_phasesel),  32'd0);
            check_eq("nostep.phasedir",  32'(pll_phasedir),  32'd1);
            check_eq("nostep.rst_out",   32'(rst_out),       32'd0);
        end
        step_valid = 1'b0;
`endif

        // Asynchronous reset while running: outputs must react with no clock edge.
        go(cyc + 3);
        #2 resetn = 1'b0;
        #1 check_reset_values("async");
        release_reset();
        bring_up(int'($urandom_range(0, 60)), r);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
